// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - register file access bundle: one write port, two read ports
interface reg_file_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) ();
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x64 architectural register file, X31 hardwired to zero
// Two combinational read ports through a mux4/mux4/mux2 tree, one clocked write port.
module reg_file #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  reg_file_if.slave  bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-2:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-2:0][DATA_W-1:0] regs_d;
  logic [NUM_REGS-1:0]             we_dec;
  logic [NUM_REGS-1:0][DATA_W-1:0] words;

  function automatic logic [DATA_W-1:0] mux2_1(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              s
  );
    return s ? b : a;
  endfunction

  function automatic logic [DATA_W-1:0] mux4_1(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] c,
    input logic [DATA_W-1:0] d,
    input logic [1:0]        s
  );
    return mux2_1(mux2_1(a, b, s[0]), mux2_1(c, d, s[0]), s[1]);
  endfunction

  // Tree shape assumes a 5-bit index: 8 leaf mux4s, 2 middle mux4s, one root mux2.
  function automatic logic [DATA_W-1:0] read_tree(
    input logic [NUM_REGS-1:0][DATA_W-1:0] w,
    input logic [ADDR_W-1:0]               idx
  );
    logic [7:0][DATA_W-1:0] lvl1;
    logic [1:0][DATA_W-1:0] lvl2;
    for (int k = 0; k < 8; k++) begin
      lvl1[k] = mux4_1(w[4*k], w[4*k+1], w[4*k+2], w[4*k+3], idx[1:0]);
    end
    for (int k = 0; k < 2; k++) begin
      lvl2[k] = mux4_1(lvl1[4*k], lvl1[4*k+1], lvl1[4*k+2], lvl1[4*k+3], idx[3:2]);
    end
    return mux2_1(lvl2[0], lvl2[1], idx[4]);
  endfunction

  always_comb begin
    we_dec = '0;
    if (bus.RegWrite) begin
      we_dec[bus.WriteRegister] = 1'b1;
    end
    we_dec[NUM_REGS-1] = 1'b0;
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (we_dec[i]) begin
        regs_d[i] = bus.WriteData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // The zero register has no storage; it is a constant leaf of the read tree.
  always_comb begin
    words                 = '0;
    words[NUM_REGS-2:0]   = regs_q;
    words[NUM_REGS-1]     = '0;
    bus.ReadData1         = read_tree(words, bus.ReadRegister1);
    bus.ReadData2         = read_tree(words, bus.ReadRegister2);
  end
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file
module tb_reg_file;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic clk;
  logic reset;
  reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned      n_checks = 0;
  int unsigned      n_errors = 0;
  logic [63:0]      model [32];
  logic [63:0]      exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
  endtask

  task automatic write_reg(input logic we, input logic [4:0] addr, input logic [63:0] data);
    @(negedge clk);
    bus.RegWrite      = we;
    bus.WriteRegister = addr;
    bus.WriteData     = data;
    @(posedge clk);
    if (we && addr != 5'd31) model[addr] = data;
    #1;
    bus.RegWrite = 1'b0;
  endtask

  task automatic read_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    bus.ReadRegister1 = a1;
    bus.ReadRegister2 = a2;
    exp_q.push_back(model[a1]);
    exp_q.push_back(model[a2]);
    #1;
    check_eq({tag, "_rd1"}, bus.ReadData1, exp_q.pop_front());
    check_eq({tag, "_rd2"}, bus.ReadData2, exp_q.pop_front());
  endtask

  initial begin
    reset             = 1'b1;
    bus.RegWrite      = 1'b0;
    bus.WriteRegister = '0;
    bus.WriteData     = '0;
    bus.ReadRegister1 = 5'd31;
    bus.ReadRegister2 = 5'd31;
    #1;
    exp_q.push_back(64'h0);
    check_eq("x31_prereset", bus.ReadData1, exp_q.pop_front());

    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) read_pair("after_reset", 5'(i), 5'(31 - i));

    for (int i = 0; i < 31; i++) write_reg(1'b1, 5'(i), {32'hDEAD0000 | 32'(i), 32'(i)});
    for (int i = 0; i < 31; i++) read_pair("pattern", 5'(i), 5'(30 - i));

    write_reg(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 32; i++) read_pair("x31_drop", 5'(i), 5'(31 - i));

    write_reg(1'b1, 5'd5, 64'h1);
    @(negedge clk);
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'd5;
    bus.WriteData     = 64'h2;
    bus.ReadRegister1 = 5'd5;
    exp_q.push_back(64'h1);
    #1;
    check_eq("rdw_old", bus.ReadData1, exp_q.pop_front());
    @(posedge clk);
    model[5] = 64'h2;
    exp_q.push_back(model[5]);
    #1;
    bus.RegWrite = 1'b0;
    check_eq("rdw_new", bus.ReadData1, exp_q.pop_front());

    write_reg(1'b0, 5'd7, 64'hABCD);
    read_pair("no_we", 5'd7, 5'd7);

    write_reg(1'b1, 5'd3, 64'h55);
    read_pair("x3_55", 5'd3, 5'd4);
    @(negedge clk);
    reset             = 1'b1;
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'd3;
    bus.WriteData     = 64'hAA;
    @(posedge clk);
    model_reset();
    #1;
    bus.RegWrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    read_pair("rst_over_we", 5'd3, 5'd30);
    write_reg(1'b1, 5'd3, 64'hAA);
    read_pair("post_rst_wr", 5'd3, 5'd3);

    for (int n = 0; n < 40; n++) begin
      write_reg(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                {$urandom, $urandom});
      read_pair("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
